// File: rtl/lutram_rf_clr.sv
// LUTRAM register file: DEPTH x WIDTH, one write port, RD_PORTS asynchronous read ports, with a clear sweep to INIT_VAL.
// Latency: writes land at the clock edge; reads are combinational. A sweep takes DEPTH cycles after RST release or CLR.
// Backpressure: READY low during the sweep, when writes are ignored. Macro WIRED_RF_BYPASS_EN selects write-first reads.
module lutram_rf_clr #(
    parameter int               DEPTH    = 32,
    parameter int               WIDTH    = 2,
    parameter int               RD_PORTS = 3,
    parameter logic [WIDTH-1:0] INIT_VAL = WIDTH'(0),
    localparam int              AW_W     = $clog2(DEPTH)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CLR,
    input  logic                      WEN,
    input  logic [AW_W-1:0]           AW,
    input  logic [WIDTH-1:0]          DI,
    input  logic [RD_PORTS*AW_W-1:0]  RA,
    output logic [RD_PORTS*WIDTH-1:0] RQ,
    output logic                      READY
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic [AW_W:0]   DEPTH_W  = (AW_W+1)'(DEPTH);
    localparam logic [AW_W-1:0] CNT_LAST = AW_W'(DEPTH - 1);

    state_t            r_state;
    logic [AW_W-1:0]   r_cnt;
    logic              r_ready;
    logic [WIDTH-1:0]  r_mem [DEPTH];

    logic              w_aw_ok;
    logic              w_user_we;
    logic              w_mem_we;
    logic [AW_W-1:0]   w_mem_wa;
    logic [WIDTH-1:0]  w_mem_wd;

    assign w_aw_ok   = ({1'b0, AW} < DEPTH_W);
    // CLR in the same cycle as WEN drops the write: the array is about to be swept anyway.
    assign w_user_we = r_ready && WEN && !CLR && w_aw_ok;
    assign w_mem_we  = !RST && ((r_state == ST_INIT) || w_user_we);
    assign w_mem_wa  = (r_state == ST_INIT) ? r_cnt : AW;
    assign w_mem_wd  = (r_state == ST_INIT) ? INIT_VAL : DI;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    // Terminal count is DEPTH-1, so non-power-of-two depths end the sweep early.
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (CLR) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (w_mem_we) begin
            r_mem[w_mem_wa] <= w_mem_wd;
        end
    end

    assign READY = r_ready;

    for (genvar g = 0; g < RD_PORTS; g++) begin : g_rd
        logic [AW_W-1:0] w_ra;
        logic            w_ra_ok;

        assign w_ra    = RA[g*AW_W +: AW_W];
        assign w_ra_ok = ({1'b0, w_ra} < DEPTH_W);

`ifdef WIRED_RF_BYPASS_EN
        // The array is logically clear for the whole sweep, whatever the sweep has reached.
        assign RQ[g*WIDTH +: WIDTH] = (!r_ready || !w_ra_ok)         ? INIT_VAL :
                                      (WEN && w_aw_ok && (AW == w_ra)) ? DI       :
                                                                         r_mem[w_ra];
`else
        assign RQ[g*WIDTH +: WIDTH] = (!r_ready || !w_ra_ok) ? INIT_VAL : r_mem[w_ra];
`endif
    end

endmodule

// File: tb/tb_lutram_rf_clr.sv
// Bench for lutram_rf_clr: a 32x2x3 instance checked against a behavioural model plus vectors,
// and a 24x6x5 instance for non-power-of-two sizing.
module tb_lutram_rf_clr;

    localparam int         D0 = 32, W0 = 2, P0 = 3, A0 = 5;
    localparam logic [1:0] IV0 = 2'b01;
    localparam int         D1 = 24, W1 = 6, P1 = 5, A1 = 5;
    localparam logic [5:0] IV1 = 6'h2A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst0, clr0, wen0, rdy0;
    logic [A0-1:0]     aw0;
    logic [W0-1:0]     di0;
    logic [P0*A0-1:0]  ra0;
    logic [P0*W0-1:0]  rq0;

    logic              rst1, clr1, wen1, rdy1;
    logic [A1-1:0]     aw1;
    logic [W1-1:0]     di1;
    logic [P1*A1-1:0]  ra1;
    logic [P1*W1-1:0]  rq1;

    lutram_rf_clr #(.DEPTH(D0), .WIDTH(W0), .RD_PORTS(P0), .INIT_VAL(IV0)) u_dut0 (
        .CLK(clk), .RST(rst0), .CLR(clr0), .WEN(wen0), .AW(aw0), .DI(di0),
        .RA(ra0), .RQ(rq0), .READY(rdy0)
    );

    lutram_rf_clr #(.DEPTH(D1), .WIDTH(W1), .RD_PORTS(P1), .INIT_VAL(IV1)) u_dut1 (
        .CLK(clk), .RST(rst1), .CLR(clr1), .WEN(wen1), .AW(aw1), .DI(di1),
        .RA(ra1), .RQ(rq1), .READY(rdy1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: contents as the user sees them, plus cycles left until usable.
    logic [1:0] m_mem [D0];
    int         m_busy;

    task automatic m_clear();
        for (int i = 0; i < D0; i++) m_mem[i] = IV0;
        m_busy = D0;
    endtask

    function automatic logic [1:0] m_read(input int ra);
        if (m_busy > 0 || ra >= D0) return IV0;
`ifdef WIRED_RF_BYPASS_EN
        if (wen0 && int'(aw0) < D0 && int'(aw0) == ra) return di0;
`endif
        return m_mem[ra];
    endfunction

    task automatic m_edge();
        if (rst0) m_clear();
        else if (m_busy > 0) m_busy--;
        else if (clr0) m_clear();
        else if (wen0 && int'(aw0) < D0) m_mem[aw0] = di0;
    endtask

    task automatic drv0(input logic r, input logic c, input logic w, input logic [4:0] a,
                        input logic [1:0] d, input logic [14:0] ra);
        rst0 = r; clr0 = c; wen0 = w; aw0 = a; di0 = d; ra0 = ra;
    endtask

    // One cycle on dut0: check outputs against the model, then clock and advance the model.
    task automatic cyc0();
        #2;
        chk("ready", 32'(rdy0), 32'(m_busy == 0));
        for (int i = 0; i < P0; i++)
            chk($sformatf("rq%0d@%0d", i, ra0[i*A0 +: A0]), 32'(rq0[i*W0 +: W0]),
                32'(m_read(int'(ra0[i*A0 +: A0]))));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Counts cycles READY stays low, driving the given inputs each cycle.
    task automatic wait_ready0(input logic c, input logic w, output int n);
        n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            drv0(1'b0, c, w, 5'd9, 2'd3, {3{5'(n)}});
            cyc0();
            n++;
        end
    endtask

    typedef struct packed {
        logic        wen;
        logic [4:0]  aw;
        logic [1:0]  di;
        logic [14:0] ra;
        logic [5:0]  ex;
    } vec_t;

    vec_t tbl [6];
    int   n;

    initial begin
        tbl[0] = '{1'b1, 5'd5,  2'd2, {5'd6,  5'd6,  5'd6},  {2'd1, 2'd1, 2'd1}};
        tbl[1] = '{1'b0, 5'd0,  2'd0, {5'd5,  5'd5,  5'd6},  {2'd2, 2'd2, 2'd1}};
        tbl[2] = '{1'b1, 5'd31, 2'd3, {5'd5,  5'd0,  5'd6},  {2'd2, 2'd1, 2'd1}};
        tbl[3] = '{1'b0, 5'd0,  2'd0, {5'd31, 5'd30, 5'd5},  {2'd3, 2'd1, 2'd2}};
        tbl[4] = '{1'b1, 5'd0,  2'd0, {5'd31, 5'd31, 5'd31}, {2'd3, 2'd3, 2'd3}};
        tbl[5] = '{1'b0, 5'd0,  2'd0, {5'd0,  5'd5,  5'd31}, {2'd0, 2'd2, 2'd3}};

        drv0(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, '0);
        rst1 = 1'b1; clr1 = 1'b0; wen1 = 1'b0; aw1 = '0; di1 = '0; ra1 = '0;
        m_clear();

        // Reset pulse, then the sweep length.
        @(posedge clk);
        m_edge();
        #1;
        drv0(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, {5'd31, 5'd17, 5'd0});
        #1;
        chk("reset_ready", 32'(rdy0), 32'd0);
        chk("reset_rq", 32'(rq0), 32'({3{IV0}}));
        #1;
        wait_ready0(1'b0, 1'b0, n);
        chk("reset_sweep_len", 32'(n), 32'd32);

        for (int a = 0; a < D0; a++) begin
            drv0(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, {3{5'(a)}});
            #1;
            chk("post_reset_all", 32'(rq0), 32'({3{IV0}}));
            #1;
            cyc0();
        end

        for (int i = 0; i < 6; i++) begin
            drv0(1'b0, 1'b0, tbl[i].wen, tbl[i].aw, tbl[i].di, tbl[i].ra);
            #2;
            chk($sformatf("vec%0d", i), 32'(rq0), 32'(tbl[i].ex));
            cyc0();
        end

        // Same-cycle write and read of entry 7.
        drv0(1'b0, 1'b0, 1'b1, 5'd7, 2'd3, {5'd0, 5'd0, 5'd7});
        #2;
`ifdef WIRED_RF_BYPASS_EN
        chk("bypass_same_cycle", 32'(rq0[1:0]), 32'd3);
`else
        chk("bypass_same_cycle", 32'(rq0[1:0]), 32'(IV0));
`endif
        cyc0();
        drv0(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, {3{5'd7}});
        #2;
        chk("bypass_next_cycle", 32'(rq0), 32'({3{2'd3}}));
        cyc0();

        // CLR and WEN together: write dropped, full sweep.
        drv0(1'b0, 1'b1, 1'b1, 5'd3, 2'd3, {3{5'd3}});
        cyc0();
        wait_ready0(1'b0, 1'b0, n);
        chk("clr_sweep_len", 32'(n), 32'd32);
        drv0(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, {5'd3, 5'd5, 5'd7});
        #2;
        chk("clr_wen_dropped", 32'(rq0), 32'({3{IV0}}));
        cyc0();

        // Reset at cnt=20 of a CLR sweep, with CLR and WEN pressed during INIT.
        drv0(1'b0, 1'b1, 1'b0, 5'd0, 2'd0, '0);
        cyc0();
        for (int i = 0; i < 20; i++) begin
            drv0(1'b0, 1'(i % 3 == 0), 1'b1, 5'd9, 2'd3, {3{5'd9}});
            cyc0();
        end
        drv0(1'b1, 1'b0, 1'b0, 5'd0, 2'd0, '0);
        cyc0();
        wait_ready0(1'b1, 1'b1, n);
        chk("midsweep_rst_len", 32'(n), 32'd32);
        drv0(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, {3{5'd9}});
        #2;
        chk("init_write_dropped", 32'(rq0), 32'({3{IV0}}));
        cyc0();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            drv0(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 39) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom), 2'($urandom), 15'($urandom));
            if ($urandom_range(0, 3) == 0) ra0[4:0] = aw0;
            cyc0();
        end
        drv0(1'b0, 1'b0, 1'b0, 5'd0, 2'd0, '0);

        // Non-power-of-two instance.
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        ra1 = {5'd28, 5'd0, 5'd23, 5'd31, 5'd5};
        #1;
        chk("np2_reset_ready", 32'(rdy1), 32'd0);
        chk("np2_reset_rq", 32'(rq1), 32'({5{IV1}}));
        n = 0;
        while (rdy1 !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("np2_sweep_len", 32'(n), 32'd24);
        wen1 = 1'b1; aw1 = 5'd28; di1 = 6'h15; ra1 = {5{5'd28}};
        #1;
        chk("np2_oor_same_cycle", 32'(rq1), 32'({5{IV1}}));
        @(posedge clk);
        #1;
        wen1 = 1'b0;
        #1;
        chk("np2_oor_write_dropped", 32'(rq1), 32'({5{IV1}}));
        wen1 = 1'b1; aw1 = 5'd23; di1 = 6'h15;
        @(posedge clk);
        #1;
        wen1 = 1'b0; ra1 = {5'd23, 5'd28, 5'd0, 5'd23, 5'd5};
        #1;
        chk("np2_last_entry", 32'(rq1), 32'({6'h15, IV1, IV1, 6'h15, IV1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lutram_rf_clr.md
# lutram_rf_clr

Parametrised multi-read-port LUTRAM register file with one write port, for rename tables, free lists and predictor state in the wired0 core. It generalises the fixed 32x2, three-read-port storage primitive to arbitrary depth, width and read-port count. It adds a hardware clear sequencer that sweeps every entry to a programmable value after reset or on request. Reads stay asynchronous, so the block drops in wherever the fixed primitive is used today.

## Interface
- DEPTH, 32: number of entries; any value ≥ 2, power of two not required.
- WIDTH, 2: bits per entry.
- RD_PORTS, 3: number of asynchronous read ports, ≥ 1.
- INIT_VAL, WIDTH'(0): value written to every entry by the clear sweep.
- AW_W: localparam, $clog2(DEPTH).
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- CLR  input  1  single-cycle request to re-clear the whole array.
- WEN  input  1  write enable.
- AW  input  AW_W  write address.
- DI  input  WIDTH  write data.
- RA  input  RD_PORTS*AW_W  read addresses; port i uses RA[i*AW_W +: AW_W].
- RQ  output  RD_PORTS*WIDTH  read data; port i drives RQ[i*WIDTH +: WIDTH].
- READY  output  1  high when the array is usable (IDLE state).

## Operation
- Storage: DEPTH x WIDTH array. Each read port is a combinational lookup of the array.
- FSM states:
  - INIT: a sweep counter `cnt` runs 0..DEPTH-1. Each cycle writes INIT_VAL to entry `cnt`. After writing DEPTH-1 the FSM moves to IDLE.
  - IDLE: READY=1. User writes are accepted.
- RST: state becomes INIT and `cnt` becomes 0, from any state. This includes mid-sweep; the sweep then restarts from 0.
- CLR in IDLE: next state is INIT with `cnt`=0. If WEN is high in the same cycle as CLR, the write is dropped (CLR wins).
- CLR in INIT: ignored; the sweep continues without restarting.
- WEN in INIT: ignored; no array update.
- Reads in INIT: every RQ port returns INIT_VAL regardless of address. The array is logically clear from the first INIT cycle.
- Out-of-range addresses (≥ DEPTH):
  - writes are dropped;
  - reads return INIT_VAL.
- Counter compare is against DEPTH-1, not against wrap of AW_W bits.
- Multiple read ports may use the same address; each port gets an identical result.

## Timing
- Reset values: READY=0, state=INIT, `cnt`=0. RQ reads INIT_VAL on every port while in INIT.
- Clear length:
  - RST held high up to edge k, low afterwards: sweep writes occur at edges k+1..k+DEPTH.
  - READY rises after edge k+DEPTH, so READY is low for exactly DEPTH cycles after RST releases.
- CLR sampled high in IDLE at edge k: READY is low from after edge k until after edge k+DEPTH.
- Write latency: a write is sampled at edge k and becomes visible on RQ after edge k. Same-cycle read behaviour is set by the Configuration macro.
- No output registers. RA→RQ is a purely combinational path.

## Configuration
- WIRED_RF_BYPASS_EN defined:
  - write-first forwarding applies when READY=1 and WEN=1 and an in-range AW equals RA[i];
  - in that case RQ[i] returns DI combinationally in the same cycle.
- WIRED_RF_BYPASS_EN undefined: RQ[i] returns the pre-write array content until the edge (read-first).
- Under both settings, INIT behaviour is unchanged and INIT_VAL still overrides all reads.

## Test plan
- Reset sweep (DEPTH=32, INIT_VAL=2'b01):
  - stimulus: pulse RST for 1 cycle;
  - response: READY=0 for 32 cycles then 1; all 3 ports read 2'b01 at every address.
- Write/read (after READY):
  - stimulus: write AW=5,DI=2'b10; then RA={5,5,6};
  - response: RQ={2'b10,2'b10,2'b01} on the following cycle.
- Same-cycle bypass:
  - stimulus: WEN, AW=7, DI=2'b11, RA[0]=7 in the same cycle;
  - response: RQ[0]=2'b11 with WIRED_RF_BYPASS_EN, old value without.
- CLR vs WEN collision:
  - stimulus: CLR=1 and WEN=1 (AW=3, DI=2'b11) in IDLE;
  - response: write dropped, READY low for 32 cycles, entry 3 reads INIT_VAL afterwards.
- Reset mid-sweep:
  - stimulus: assert RST at cnt=20; also CLR and WEN during INIT;
  - response: sweep restarts at 0, READY rises 32 cycles after RST release, no user write lands.
- Non-power-of-two sizing:
  - stimulus: DEPTH=24, WIDTH=6, RD_PORTS=5; read and write address 28;
  - response: READY after 24 cycles; write to 28 ignored; read of 28 returns INIT_VAL.
